reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encodings and default timing constants shared by the reset sequencer.
// Rev 1.0
`default_nettype none

package reset_seq_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_STAGE_DELAY     = 8;
   localparam int DEF_SW_RST_CYCLES   = 4;
   localparam int CNT_W               = 8;

   typedef enum logic [2:0] {
      ST_HOLD       = 3'd0,
      ST_DEBOUNCE   = 3'd1,
      ST_REL_CORE   = 3'd2,
      ST_REL_PERIPH = 3'd3,
      ST_RUN        = 3'd4,
      ST_SW_RST     = 3'd5
   } seq_state_t;

   // Terminal counter value for a phase that lasts 'cycles' clock cycles.
   function automatic logic [CNT_W-1:0] last_count(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop level synchronizer with asynchronous active-low clear.
// Rev 1.0
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// reset_sequencer: debounces POR/supply-good and releases core, peripheral and user resets in order.
// Rev 1.0
`default_nettype none

module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int STAGE_DELAY     = DEF_STAGE_DELAY,
   parameter int SW_RST_CYCLES   = DEF_SW_RST_CYCLES
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       porb_raw,
   input  logic       pwr_good,
   input  logic       sw_reset_req,
   output logic       rstb_core,
   output logic       rstb_periph,
   output logic       rstb_user,
   output logic       seq_busy,
   output logic [2:0] seq_state,
   output logic [7:0] drop_count
);

   localparam logic [CNT_W-1:0] c_DEB_LAST   = last_count(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] c_STAGE_LAST = last_count(STAGE_DELAY);
   localparam logic [CNT_W-1:0] c_SW_LAST    = last_count(SW_RST_CYCLES);

   logic             w_por_s;
   logic             w_pwr_s;
   logic             w_ok_s;

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timed;
   logic             r_rstb_core;
   logic             r_rstb_periph;
   logic             r_rstb_user;
   logic [7:0]       r_drop_cnt;
   logic             w_core_nxt;
   logic             w_periph_nxt;
   logic             w_user_nxt;
   logic             w_drop_inc;

   sync_2ff u_sync_por (
      .clk   (clock),
      .rst_n (resetb),
      .i_d   (porb_raw),
      .o_q   (w_por_s)
   );

   sync_2ff u_sync_pwr (
      .clk   (clock),
      .rst_n (resetb),
      .i_d   (pwr_good),
      .o_q   (w_pwr_s)
   );

   assign w_ok_s = w_por_s & w_pwr_s;

   // State register; reset outputs are registered from the next state so they change on the same edge.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state       <= ST_HOLD;
         r_cnt         <= '0;
         r_rstb_core   <= 1'b0;
         r_rstb_periph <= 1'b0;
         r_rstb_user   <= 1'b0;
         r_drop_cnt    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_rstb_core   <= w_core_nxt;
         r_rstb_periph <= w_periph_nxt;
         r_rstb_user   <= w_user_nxt;
         if (w_drop_inc) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HOLD: begin
            if (w_ok_s) w_state_nxt = ST_DEBOUNCE;
         end
         ST_DEBOUNCE: begin
            if (!w_ok_s)                  w_state_nxt = ST_HOLD;
            else if (r_cnt == c_DEB_LAST) w_state_nxt = ST_REL_CORE;
         end
         ST_REL_CORE: begin
            if (!w_ok_s)                    w_state_nxt = ST_HOLD;
            else if (r_cnt == c_STAGE_LAST) w_state_nxt = ST_REL_PERIPH;
         end
         ST_REL_PERIPH: begin
            if (!w_ok_s)                    w_state_nxt = ST_HOLD;
            else if (r_cnt == c_STAGE_LAST) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Supply loss outranks a simultaneous software request.
            if (!w_ok_s)           w_state_nxt = ST_HOLD;
            else if (sw_reset_req) w_state_nxt = ST_SW_RST;
         end
         ST_SW_RST: begin
            if (!w_ok_s)                 w_state_nxt = ST_HOLD;
            else if (r_cnt == c_SW_LAST) w_state_nxt = ST_REL_CORE;
         end
         default: w_state_nxt = ST_HOLD;
      endcase
   end

   always_comb begin
      w_timed = (r_state == ST_DEBOUNCE) || (r_state == ST_REL_CORE) ||
                (r_state == ST_REL_PERIPH) || (r_state == ST_SW_RST);
      w_cnt_nxt = '0;
      if (w_timed && (w_state_nxt == r_state)) begin
         w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 8'd1;
      end

      w_core_nxt   = (w_state_nxt == ST_REL_CORE) || (w_state_nxt == ST_REL_PERIPH) ||
                     (w_state_nxt == ST_RUN)      || (w_state_nxt == ST_SW_RST);
      w_periph_nxt = (w_state_nxt == ST_REL_PERIPH) || (w_state_nxt == ST_RUN);
      w_user_nxt   = (w_state_nxt == ST_RUN);
      w_drop_inc   = (r_state == ST_RUN) && (w_state_nxt == ST_HOLD) && (r_drop_cnt != 8'hFF);
   end

   assign rstb_core   = r_rstb_core;
   assign rstb_periph = r_rstb_periph;
   assign rstb_user   = r_rstb_user;
   assign seq_busy    = (r_state != ST_RUN);
   assign seq_state   = r_state;
   assign drop_count  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; expected output snapshots are queued with a target cycle.
// Rev 1.0
`default_nettype none

module tb_reset_sequencer;
   import reset_seq_pkg::*;

   logic       clock        = 1'b0;
   logic       resetb       = 1'b0;
   logic       porb_raw     = 1'b0;
   logic       pwr_good     = 1'b0;
   logic       sw_reset_req = 1'b0;
   logic       rstb_core;
   logic       rstb_periph;
   logic       rstb_user;
   logic       seq_busy;
   logic [2:0] seq_state;
   logic [7:0] drop_count;

   reset_sequencer dut (
      .clock        (clock),
      .resetb       (resetb),
      .porb_raw     (porb_raw),
      .pwr_good     (pwr_good),
      .sw_reset_req (sw_reset_req),
      .rstb_core    (rstb_core),
      .rstb_periph  (rstb_periph),
      .rstb_user    (rstb_user),
      .seq_busy     (seq_busy),
      .seq_state    (seq_state),
      .drop_count   (drop_count)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          at;
      string       tag;
      logic [14:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   logic [14:0] w_obs;
   assign w_obs = {seq_state, rstb_core, rstb_periph, rstb_user, seq_busy, drop_count};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [14:0] pk(input seq_state_t st, input logic c, input logic p,
                                      input logic u, input logic [7:0] d);
      return {st, c, p, u, (st != ST_RUN), d};
   endfunction

   task automatic expect_at(input int at, input string tag, input logic [14:0] e);
      sb_t ent;
      int  i;
      ent.at  = at;
      ent.tag = tag;
      ent.exp = e;
      i = 0;
      while (i < sb_q.size() && sb_q[i].at <= at) i++;
      sb_q.insert(i, ent);
   endtask

   // Expected snapshots for a full release sequence whose synchronized ok rises at edge n.
   task automatic push_bringup(input int n, input logic [7:0] d);
      expect_at(n,      "bu_hold",        pk(ST_HOLD,       1'b0, 1'b0, 1'b0, d));
      expect_at(n + 1,  "bu_debounce",    pk(ST_DEBOUNCE,   1'b0, 1'b0, 1'b0, d));
      expect_at(n + 16, "bu_deb_last",    pk(ST_DEBOUNCE,   1'b0, 1'b0, 1'b0, d));
      expect_at(n + 17, "bu_core",        pk(ST_REL_CORE,   1'b1, 1'b0, 1'b0, d));
      expect_at(n + 24, "bu_core_last",   pk(ST_REL_CORE,   1'b1, 1'b0, 1'b0, d));
      expect_at(n + 25, "bu_periph",      pk(ST_REL_PERIPH, 1'b1, 1'b1, 1'b0, d));
      expect_at(n + 32, "bu_periph_last", pk(ST_REL_PERIPH, 1'b1, 1'b1, 1'b0, d));
      expect_at(n + 33, "bu_user",        pk(ST_RUN,        1'b1, 1'b1, 1'b1, d));
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   always @(negedge clock) begin
      sb_t e;
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
         e = sb_q.pop_front();
         check_val(e.tag, {17'd0, w_obs}, {17'd0, e.exp});
      end
   end

   initial begin
      int         c;
      logic [7:0] d;

      // Reset state, then idle in HOLD with only supply-good present
      pwr_good = 1'b1;
      repeat (3) @(negedge clock);
      check_val("rst_state", {17'd0, w_obs}, {17'd0, pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd0)});
      resetb = 1'b1;
      c = cyc;
      expect_at(c + 4, "idle_hold", pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd0));
      wait_to(c + 6);

      // Short POR pulse that ends during debounce
      c = cyc;
      porb_raw = 1'b1;
      expect_at(c + 3,  "pulse_deb",      pk(ST_DEBOUNCE, 1'b0, 1'b0, 1'b0, 8'd0));
      expect_at(c + 12, "pulse_deb_end",  pk(ST_DEBOUNCE, 1'b0, 1'b0, 1'b0, 8'd0));
      expect_at(c + 13, "pulse_hold",     pk(ST_HOLD,     1'b0, 1'b0, 1'b0, 8'd0));
      expect_at(c + 20, "pulse_hold_out", pk(ST_HOLD,     1'b0, 1'b0, 1'b0, 8'd0));
      wait_to(c + 10);
      porb_raw = 1'b0;
      wait_to(c + 22);

      // Full bring-up with default timing
      c = cyc;
      porb_raw = 1'b1;
      push_bringup(c + 2, 8'd0);
      wait_to(c + 40);

      // Software reset from RUN; a second request during REL_CORE must be ignored
      c = cyc;
      sw_reset_req = 1'b1;
      expect_at(c + 1,  "sw_enter",       pk(ST_SW_RST,     1'b1, 1'b0, 1'b0, 8'd0));
      expect_at(c + 4,  "sw_last",        pk(ST_SW_RST,     1'b1, 1'b0, 1'b0, 8'd0));
      expect_at(c + 5,  "sw_core",        pk(ST_REL_CORE,   1'b1, 1'b0, 1'b0, 8'd0));
      expect_at(c + 8,  "sw_ignored",     pk(ST_REL_CORE,   1'b1, 1'b0, 1'b0, 8'd0));
      expect_at(c + 12, "sw_core_last",   pk(ST_REL_CORE,   1'b1, 1'b0, 1'b0, 8'd0));
      expect_at(c + 13, "sw_periph",      pk(ST_REL_PERIPH, 1'b1, 1'b1, 1'b0, 8'd0));
      expect_at(c + 20, "sw_periph_last", pk(ST_REL_PERIPH, 1'b1, 1'b1, 1'b0, 8'd0));
      expect_at(c + 21, "sw_run",         pk(ST_RUN,        1'b1, 1'b1, 1'b1, 8'd0));
      @(negedge clock);
      sw_reset_req = 1'b0;
      wait_to(c + 7);
      sw_reset_req = 1'b1;
      @(negedge clock);
      sw_reset_req = 1'b0;
      wait_to(c + 25);

      // Supply drop in RUN for three cycles
      c = cyc;
      pwr_good = 1'b0;
      expect_at(c + 2, "drop_still_run", pk(ST_RUN,  1'b1, 1'b1, 1'b1, 8'd0));
      expect_at(c + 3, "drop_hold",      pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd1));
      push_bringup(c + 5, 8'd1);
      wait_to(c + 3);
      pwr_good = 1'b1;
      wait_to(c + 40);

      // Software request in the same cycle the supply drop reaches the FSM
      c = cyc;
      pwr_good = 1'b0;
      expect_at(c + 3, "prio_hold", pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd2));
      push_bringup(c + 5, 8'd2);
      wait_to(c + 2);
      sw_reset_req = 1'b1;
      @(negedge clock);
      sw_reset_req = 1'b0;
      pwr_good = 1'b1;
      wait_to(c + 40);

      // Saturation of the drop counter
      for (int k = 0; k < 300; k++) begin
         c = cyc;
         d = (k + 3 > 255) ? 8'd255 : 8'(k + 3);
         pwr_good = 1'b0;
         expect_at(c + 3,  "sat_drop", pk(ST_HOLD, 1'b0, 1'b0, 1'b0, d));
         expect_at(c + 38, "sat_run",  pk(ST_RUN,  1'b1, 1'b1, 1'b1, d));
         wait_to(c + 3);
         pwr_good = 1'b1;
         wait_to(c + 39);
      end
      check_val("sat_final", {24'd0, drop_count}, 32'd255);

      // Clean restart, then asynchronous reset in the middle of REL_PERIPH
      @(negedge clock);
      resetb = 1'b0;
      #1;
      check_val("rst_clear", {17'd0, w_obs}, {17'd0, pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd0)});
      @(negedge clock);
      resetb = 1'b1;
      c = cyc;
      expect_at(c + 2,  "mid_hold",   pk(ST_HOLD,       1'b0, 1'b0, 1'b0, 8'd0));
      expect_at(c + 19, "mid_core",   pk(ST_REL_CORE,   1'b1, 1'b0, 1'b0, 8'd0));
      expect_at(c + 27, "mid_periph", pk(ST_REL_PERIPH, 1'b1, 1'b1, 1'b0, 8'd0));
      wait_to(c + 30);
      #2;
      resetb = 1'b0;
      #1;
      check_val("rst_async", {17'd0, w_obs}, {17'd0, pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd0)});
      @(negedge clock);
      check_val("rst_held", {17'd0, w_obs}, {17'd0, pk(ST_HOLD, 1'b0, 1'b0, 1'b0, 8'd0)});
      resetb = 1'b1;
      c = cyc;
      push_bringup(c + 2, 8'd0);
      wait_to(c + 40);

      check_val("sb_drain", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
